// File: rtl/wam_pkg.sv
// Shared types and helpers for the whack-a-mole autoplayer.
package wam_pkg;

  localparam int unsigned MAX_MOLES = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REACT,
    PRESS,
    RELEASE
  } state_e;

  function automatic logic is_onehot(input logic [MAX_MOLES-1:0] v);
    return (v != '0) && ((v & (v - MAX_MOLES'(1))) == '0);
  endfunction

  // Rotate the low n bits of v left by one; bits at or above n stay zero.
  function automatic logic [MAX_MOLES-1:0] rotl1(input logic [MAX_MOLES-1:0] v,
                                                 input int unsigned n);
    logic [MAX_MOLES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_MOLES; i++) begin
      if (i < n) r[5'((i + 1) % n)] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/wam_sat_counter.sv
// Saturating up-counter used for the autoplayer statistics.
module wam_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/wam_autoplayer.sv
// Autoplayer: watches the mole vector and presses the matching button after a delay.
module wam_autoplayer
  import wam_pkg::*;
#(
  parameter int unsigned NUM_MOLES       = 8,
  parameter int unsigned DELAY_W         = 8,
  parameter int unsigned PRESS_CYCLES    = 4,
  parameter int unsigned RELEASE_TIMEOUT = 255,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_MOLES-1:0] mole_in,
  input  logic [DELAY_W-1:0]   react_delay,
  input  logic                 miss_inject,
  output logic [NUM_MOLES-1:0] btn_out,
  output logic                 busy,
  output logic [CNT_W-1:0]     presses,
  output logic [CNT_W-1:0]     timeouts
);

  localparam int unsigned CW_P = $clog2(PRESS_CYCLES + 1);
  localparam int unsigned CW_R = $clog2(RELEASE_TIMEOUT + 1);
  localparam int unsigned CW_PR = (CW_P > CW_R) ? CW_P : CW_R;
  localparam int unsigned CW = (DELAY_W > CW_PR) ? DELAY_W : CW_PR;

  state_e               state_q, state_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d, mole_q2, mole2_d;
  logic [NUM_MOLES-1:0] mask_q, mask_d, tgt_q, tgt_d, btn_q, btn_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mole_valid, press_inc, timeout_inc;
  logic [NUM_MOLES-1:0] capture_mask;

  always_comb begin
    mole_d       = mole_in;
    mole2_d      = mole_q;
    mole_valid   = is_onehot(MAX_MOLES'(mole_q)) && (mole_q == mole_q2);
    capture_mask = miss_inject ? NUM_MOLES'(rotl1(MAX_MOLES'(mole_q), NUM_MOLES)) : mole_q;
  end

  // One down-counter is shared by the reaction, press and release-timeout phases.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    tgt_d       = tgt_q;
    btn_d       = btn_q;
    press_inc   = 1'b0;
    timeout_inc = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      btn_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          btn_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          btn_d = '0;
          if (mole_valid) begin
            mask_d = capture_mask;
            tgt_d  = mole_q;
            if (react_delay == '0) begin
              state_d   = PRESS;
              btn_d     = capture_mask;
              cnt_d     = CW'(PRESS_CYCLES);
              press_inc = 1'b1;
            end else begin
              state_d = REACT;
              cnt_d   = CW'(react_delay);
            end
          end
        end
        REACT: begin
          if (mole_q != tgt_q) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CW'(1)) begin
            state_d   = PRESS;
            btn_d     = mask_q;
            cnt_d     = CW'(PRESS_CYCLES);
            press_inc = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        PRESS: begin
          if (cnt_q == CW'(1)) begin
            state_d = RELEASE;
            btn_d   = '0;
            cnt_d   = CW'(RELEASE_TIMEOUT);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RELEASE: begin
          if (mole_q != tgt_q) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CW'(1)) begin
            state_d     = WAIT;
            cnt_d       = '0;
            timeout_inc = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          btn_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mole_q  <= '0;
      mole_q2 <= '0;
      mask_q  <= '0;
      tgt_q   <= '0;
      btn_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mole_q  <= mole_d;
      mole_q2 <= mole2_d;
      mask_q  <= mask_d;
      tgt_q   <= tgt_d;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb busy = (state_q == REACT) || (state_q == PRESS) || (state_q == RELEASE);
  assign btn_out = btn_q;

  wam_sat_counter #(.CNT_W(CNT_W)) u_press_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (press_inc),
    .count(presses)
  );

  wam_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (timeout_inc),
    .count(timeouts)
  );

endmodule

// File: tb/tb_wam_autoplayer.sv
// Self-checking bench for wam_autoplayer: directed tables, corner sequences, random vs. model.
module tb_wam_autoplayer;

  localparam int PC = 4;
  localparam int RT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] mole_in = '0;
  logic [7:0] react_delay = '0;
  logic       miss_inject = 1'b0;
  logic [7:0] btn_out;
  logic       busy;
  logic [7:0] presses;
  logic [7:0] timeouts;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  wam_autoplayer #(
    .NUM_MOLES(8), .DELAY_W(8), .PRESS_CYCLES(PC), .RELEASE_TIMEOUT(RT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mole_in(mole_in),
    .react_delay(react_delay), .miss_inject(miss_inject),
    .btn_out(btn_out), .busy(busy), .presses(presses), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: phases with absolute-cycle deadlines.
  // ph: 0 off, 1 waiting, 2 reacting, 3 pressing, 4 releasing
  int         cyc = 0, ph = 0, dl = 0, m_np = 0, m_nt = 0;
  logic [7:0] m1 = '0, m2 = '0, m_mask = '0, m_tgt = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = 0; m1 = '0; m2 = '0; m_np = 0; m_nt = 0;
    end else begin
      if (!enable) ph = 0;
      else begin
        case (ph)
          0: ph = 1;
          1: if ($countones(m1) == 1 && m1 == m2) begin
               m_tgt  = m1;
               m_mask = miss_inject ? {m1[6:0], m1[7]} : m1;
               if (react_delay == 0) begin
                 ph = 3; dl = cyc + PC; m_np = (m_np < 255) ? m_np + 1 : 255;
               end else begin
                 ph = 2; dl = cyc + int'(react_delay);
               end
             end
          2: if (m1 != m_tgt) ph = 1;
             else if (cyc == dl) begin
               ph = 3; dl = cyc + PC; m_np = (m_np < 255) ? m_np + 1 : 255;
             end
          3: if (cyc == dl) begin ph = 4; dl = cyc + RT; end
          4: if (m1 != m_tgt) ph = 1;
             else if (cyc == dl) begin ph = 1; m_nt = (m_nt < 255) ? m_nt + 1 : 255; end
          default: ph = 0;
        endcase
      end
      m2 = m1;
      m1 = mole_in;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_btn", int'(btn_out), (ph == 3) ? int'(m_mask) : 0);
      check("model_busy", int'(busy), (ph >= 2) ? 1 : 0);
      check("model_presses", int'(presses), m_np);
      check("model_timeouts", int'(timeouts), m_nt);
    end
  end

  typedef struct {
    logic [7:0] mole;
    int         d;
    bit         miss;
    logic [7:0] exp_btn;
    int         exp_first;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    mole_in = '0;
    repeat (6) tick();
  endtask

  initial begin
    int first, hi, p0, t0;
    bit busy_seen;
    logic [7:0] bv, prev;
    int rises[$];

    tbl[0] = '{8'h04, 3, 1'b0, 8'h04, 5};
    tbl[1] = '{8'h80, 0, 1'b1, 8'h01, 2};
    tbl[2] = '{8'h01, 7, 1'b1, 8'h02, 9};
    tbl[3] = '{8'h40, 1, 1'b0, 8'h40, 3};
    tbl[4] = '{8'h03, 2, 1'b0, 8'h00, -1};
    tbl[5] = '{8'h00, 0, 1'b0, 8'h00, -1};
    tbl[6] = '{8'h81, 0, 1'b1, 8'h00, -1};

    repeat (3) tick();
    check("reset_btn", int'(btn_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_presses", int'(presses), 0);
    check("reset_timeouts", int'(timeouts), 0);
    rst = 1'b0;
    enable = 1'b1;
    chk_on = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 7; i++) begin
      mole_in = tbl[i].mole; react_delay = 8'(tbl[i].d); miss_inject = tbl[i].miss;
      p0 = int'(presses); first = -1; hi = 0; busy_seen = 0; bv = '0;
      for (int e = 0; e < 50; e++) begin
        tick();
        if (btn_out != 0) begin
          if (first < 0) begin first = e; bv = btn_out; end
          hi++;
        end
        if (busy) busy_seen = 1;
      end
      check($sformatf("tbl%0d_first", i), first, tbl[i].exp_first);
      check($sformatf("tbl%0d_btn", i), int'(bv), int'(tbl[i].exp_btn));
      check($sformatf("tbl%0d_len", i), hi, (tbl[i].exp_first >= 0) ? PC : 0);
      check($sformatf("tbl%0d_presses", i), int'(presses) - p0, (tbl[i].exp_first >= 0) ? 1 : 0);
      check($sformatf("tbl%0d_busy", i), int'(busy_seen), (tbl[i].exp_first >= 0) ? 1 : 0);
      miss_inject = 1'b0;
      settle();
    end

    // Reaction aborted when the mole disappears.
    mole_in = 8'h02; react_delay = 8'd10; p0 = int'(presses); hi = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (btn_out != 0) hi++;
      if (e == 5) mole_in = 8'h00;
    end
    check("abort_btn", hi, 0);
    check("abort_presses", int'(presses) - p0, 0);
    check("abort_busy", int'(busy), 0);
    settle();

    // Stuck mole: timeout then re-press.
    mole_in = 8'h10; react_delay = 8'd1; t0 = int'(timeouts); prev = '0;
    rises.delete();
    for (int e = 0; e < 300; e++) begin
      tick();
      if (btn_out != 0 && prev == 0) rises.push_back(e);
      prev = btn_out;
    end
    check("stuck_rises", rises.size(), 2);
    if (rises.size() >= 2) begin
      check("stuck_first", rises[0], 3);
      check("stuck_second", rises[1], 264);
    end
    check("stuck_timeouts", int'(timeouts) - t0, 1);
    settle();

    // Disable mid-press.
    mole_in = 8'h20; react_delay = 8'd0;
    for (int e = 0; e < 4; e++) tick();
    check("dis_btn_before", int'(btn_out), 8'h20);
    enable = 1'b0;
    tick();
    check("dis_btn_after", int'(btn_out), 0);
    check("dis_busy_after", int'(busy), 0);
    enable = 1'b1;
    settle();

    // Reset mid-react.
    mole_in = 8'h08; react_delay = 8'd20;
    for (int e = 0; e < 6; e++) tick();
    check("rst_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("rst_btn", int'(btn_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_presses", int'(presses), 0);
    check("rst_timeouts", int'(timeouts), 0);
    rst = 1'b0;
    settle();

    // Random stimulus against the model.
    for (int s = 0; s < 150; s++) begin
      int r, len;
      r = int'($urandom_range(0, 9));
      if (r < 7) mole_in = 8'h01 << $urandom_range(0, 7);
      else if (r == 7) mole_in = 8'h00;
      else mole_in = 8'($urandom);
      react_delay = 8'($urandom_range(0, 6));
      miss_inject = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 19) != 0);
      len = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(1, 20));
      repeat (len) tick();
    end
    enable = 1'b1; miss_inject = 1'b0;
    settle();

    // Press-counter saturation.
    react_delay = 8'd0;
    for (int k = 0; k < 262; k++) begin
      mole_in = 8'h01 << (k % 8);
      repeat (8) tick();
      mole_in = 8'h00;
      repeat (4) tick();
    end
    check("sat_presses", int'(presses), 255);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
